// File: rtl/score_overlay_pkg.sv
// Shared constants for the score overlay: FSM encoding, seven-segment
// lookup, segment rectangles in unscaled cell coordinates and the cell pitch.
package score_overlay_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_COMMIT  = 2'd2
   } state_t;

   localparam int CELL_PITCH = 16;
   localparam int CELL_W     = 12;
   localparam int CELL_H     = 22;

   // Segment bit order: bit0 = A ... bit6 = G. Index 0 is the rightmost entry.
   localparam logic [9:0][6:0] SEG_LUT = {
      7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   // Inclusive rectangles, listed G,F,E,D,C,B,A so that [0] is segment A.
   localparam logic [6:0][4:0] SEG_XA = {5'd2,  5'd0, 5'd0,  5'd2,  5'd10, 5'd10, 5'd2};
   localparam logic [6:0][4:0] SEG_XB = {5'd9,  5'd1, 5'd1,  5'd9,  5'd11, 5'd11, 5'd9};
   localparam logic [6:0][4:0] SEG_YA = {5'd10, 5'd2, 5'd12, 5'd20, 5'd12, 5'd2,  5'd0};
   localparam logic [6:0][4:0] SEG_YB = {5'd11, 5'd9, 5'd19, 5'd21, 5'd19, 5'd9,  5'd1};

   function automatic logic [6:0] seg_decode(input logic [3:0] digit);
      seg_decode = (digit <= 4'd9) ? SEG_LUT[digit] : 7'h00;
   endfunction

endpackage

// File: rtl/score_overlay_bin2bcd_seq.sv
// Iterative binary-to-BCD converter (shift-add-3, one bit per clock).
// o_done flags the cycle whose clock edge performs the final shift.
module bin2bcd_seq
   import score_overlay_pkg::*;
#(
   parameter int SCORE_W = 10,
   parameter int DIGITS  = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   input  logic [SCORE_W-1:0]    i_bin,
   output logic                  o_done,
   output logic [4*DIGITS-1:0]   o_bcd,
   output logic                  o_ovf
);

   localparam int          CNT_W   = $clog2(SCORE_W + 1);
   localparam logic [31:0] MAX_VAL = 32'(10**DIGITS - 1);

   logic [SCORE_W-1:0]  r_sh;
   logic [4*DIGITS-1:0] r_bcd;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_ovf;
   logic [4*DIGITS-1:0] w_adj;

   always_comb begin
      w_adj = r_bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sh  <= '0;
         r_bcd <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else if (r_cnt != '0) begin
         r_bcd <= {w_adj[4*DIGITS-2:0], r_sh[SCORE_W-1]};
         r_sh  <= r_sh << 1;
         r_cnt <= r_cnt - 1'b1;
      end else if (i_start) begin
         r_sh  <= i_bin;
         r_bcd <= '0;
         r_cnt <= CNT_W'(SCORE_W);
         r_ovf <= 32'(i_bin) > MAX_VAL;
      end
   end

   assign o_done = (r_cnt == CNT_W'(1));
   assign o_bcd  = r_ovf ? {DIGITS{4'h9}} : r_bcd;
   assign o_ovf  = r_ovf;

endmodule

// File: rtl/score_overlay.sv
// Seven-segment score overlay: accepts a binary score, converts it to BCD,
// swaps it into the display register on a chosen line, and draws it over bg.
//
// state      | meaning
// ST_IDLE    | ready for a new score
// ST_CONVERT | shift-add-3 conversion running, SCORE_W cycles
// ST_COMMIT  | waiting for vCount == COMMIT_LINE to swap in the new digits
module score_overlay
   import score_overlay_pkg::*;
#(
   parameter int          DIGITS      = 3,
   parameter int          SCORE_W     = 10,
   parameter int          X0          = 742,
   parameter int          Y0          = 38,
   parameter int          SCALE       = 1,
   parameter logic [11:0] FG          = 12'hFFF,
   parameter int          BLANK_LZ    = 1,
   parameter int          COMMIT_LINE = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [SCORE_W-1:0] score,
   input  logic               score_valid,
   output logic               score_ready,
   input  logic               bright,
   input  logic [9:0]         hCount,
   input  logic [9:0]         vCount,
   input  logic [11:0]        bg,
   output logic [11:0]        rgb,
   output logic               pix_on,
   output logic               busy,
   output logic               ovf
);

   state_t              r_state, w_state_nxt;
   logic                w_start, w_commit, w_done, w_conv_ovf;
   logic [4*DIGITS-1:0] w_bcd;
   logic [4*DIGITS-1:0] r_disp;
   logic                r_ovf;
   logic                w_lit;
   logic [10:0]         w_hx, w_vy;

   bin2bcd_seq #(.SCORE_W(SCORE_W), .DIGITS(DIGITS)) u_bin2bcd (
      .clk     (clk),
      .rst     (rst),
      .i_start (w_start),
      .i_bin   (score),
      .o_done  (w_done),
      .o_bcd   (w_bcd),
      .o_ovf   (w_conv_ovf)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      score_ready = 1'b0;
      w_start     = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            score_ready = 1'b1;
            if (score_valid) begin
               w_start     = 1'b1;
               w_state_nxt = ST_CONVERT;
            end
         end
         ST_CONVERT: if (w_done) w_state_nxt = ST_COMMIT;
         ST_COMMIT: begin
            if (vCount == 10'(COMMIT_LINE)) begin
               w_commit    = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign busy = !score_ready;

   // The whole digit set swaps in one edge, so a frame never shows a mix.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_disp <= '0;
         r_ovf  <= 1'b0;
      end else if (w_commit) begin
         r_disp <= w_bcd;
         r_ovf  <= w_conv_ovf;
      end
   end

   assign ovf  = r_ovf;
   assign w_hx = {1'b0, hCount};
   assign w_vy = {1'b0, vCount};

   always_comb begin
      logic        lz;
      logic [3:0]  dig;
      logic [6:0]  segs;
      logic [10:0] cx0, rx, ry;
      logic        in_cell;
      w_lit   = 1'b0;
      lz      = 1'b1;
      dig     = '0;
      segs    = '0;
      cx0     = '0;
      rx      = '0;
      in_cell = 1'b0;
      ry      = w_vy - 11'(Y0);
      for (int d = 0; d < DIGITS; d++) begin
         dig  = r_disp[4*(DIGITS-1-d) +: 4];
         lz   = lz && (dig == 4'd0);
         segs = seg_decode(dig);
         if (BLANK_LZ != 0 && lz && d != DIGITS-1) segs = '0;
         cx0     = 11'(X0 + d*CELL_PITCH*SCALE);
         rx      = w_hx - cx0;
         in_cell = (w_hx >= cx0) && (rx < 11'(CELL_W*SCALE)) &&
                   (w_vy >= 11'(Y0)) && (ry < 11'(CELL_H*SCALE));
         for (int s = 0; s < 7; s++) begin
            if (in_cell && segs[s] &&
                rx >= 11'(SEG_XA[s]*SCALE) && rx < 11'((SEG_XB[s]+1)*SCALE) &&
                ry >= 11'(SEG_YA[s]*SCALE) && ry < 11'((SEG_YB[s]+1)*SCALE))
               w_lit = 1'b1;
         end
      end
   end

   assign pix_on = bright && w_lit;
   assign rgb    = !bright ? 12'h000 : (pix_on ? FG : bg);

endmodule

// File: tb/tb_score_overlay.sv
// Directed bench for score_overlay: pixel vectors on the reset display,
// then multi-cycle sequences for conversion, saturation, commit timing and reset abort.
module tb_score_overlay;
   localparam int SW = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [SW-1:0] score = '0;
   logic          score_valid = 1'b0;
   logic          score_ready;
   logic          bright = 1'b0;
   logic [9:0]    hCount = '0, vCount = '0;
   logic [11:0]   bg = 12'h123;
   logic [11:0]   rgb;
   logic          pix_on, busy, ovf;

   int n_vec = 0;
   int n_err = 0;

   // X0 = 710 puts the ones cell at x 742..753; tens 726..737; hundreds 710..721.
   score_overlay #(.DIGITS(3), .SCORE_W(SW), .X0(710), .Y0(38)) dut (
      .clk(clk), .rst(rst), .score(score), .score_valid(score_valid),
      .score_ready(score_ready), .bright(bright), .hCount(hCount),
      .vCount(vCount), .bg(bg), .rgb(rgb), .pix_on(pix_on), .busy(busy), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [9:0]  h, v;
      logic        br;
      logic        exp_on;
      logic [11:0] exp_rgb;
   } vec_t;

   vec_t tbl[15];

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic px(input string nm, input logic [9:0] h, input logic [9:0] v, input logic exp_on);
      hCount = h; vCount = v; bright = 1'b1; bg = 12'h123;
      #1;
      cmp({nm, "_on"}, 32'(pix_on), 32'(exp_on));
      cmp({nm, "_rgb"}, 32'(rgb), exp_on ? 32'hFFF : 32'h123);
   endtask

   task automatic offer(input logic [SW-1:0] val, output int cyc);
      score = val; score_valid = 1'b1;
      @(posedge clk); #1;
      score_valid = 1'b0;
      cyc = 0;
      while (busy && cyc < 200) begin
         cyc++;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int  cyc;
      logic ready_seen;

      tbl[0]  = '{"ones_A_748",   10'd748, 10'd38, 1'b1, 1'b1, 12'hFFF};
      tbl[1]  = '{"tens_A",       10'd731, 10'd38, 1'b1, 1'b0, 12'h123};
      tbl[2]  = '{"hund_A",       10'd715, 10'd38, 1'b1, 1'b0, 12'h123};
      tbl[3]  = '{"ones_G",       10'd747, 10'd48, 1'b1, 1'b0, 12'h123};
      tbl[4]  = '{"ones_B",       10'd752, 10'd43, 1'b1, 1'b1, 12'hFFF};
      tbl[5]  = '{"ones_E",       10'd742, 10'd53, 1'b1, 1'b1, 12'hFFF};
      tbl[6]  = '{"ones_D",       10'd747, 10'd58, 1'b1, 1'b1, 12'hFFF};
      tbl[7]  = '{"cell_corner",  10'd742, 10'd38, 1'b1, 1'b0, 12'h123};
      tbl[8]  = '{"A_left_edge",  10'd744, 10'd38, 1'b1, 1'b1, 12'hFFF};
      tbl[9]  = '{"A_right_edge", 10'd751, 10'd39, 1'b1, 1'b1, 12'hFFF};
      tbl[10] = '{"A_past_edge",  10'd752, 10'd38, 1'b1, 1'b0, 12'h123};
      tbl[11] = '{"D_bottom",     10'd747, 10'd59, 1'b1, 1'b1, 12'hFFF};
      tbl[12] = '{"below_cell",   10'd747, 10'd60, 1'b1, 1'b0, 12'h123};
      tbl[13] = '{"dark_pixel",   10'd748, 10'd38, 1'b0, 1'b0, 12'h000};
      tbl[14] = '{"cell_gap",     10'd740, 10'd40, 1'b1, 1'b0, 12'h123};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      cmp("rst_busy", 32'(busy), 0);
      cmp("rst_ready", 32'(score_ready), 1);
      cmp("rst_ovf", 32'(ovf), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Test 1: reset display "0"
      for (int i = 0; i < 15; i++) begin
         hCount = tbl[i].h; vCount = tbl[i].v; bright = tbl[i].br; bg = 12'h123;
         #1;
         cmp({tbl[i].name, "_on"}, 32'(pix_on), 32'(tbl[i].exp_on));
         cmp({tbl[i].name, "_rgb"}, 32'(rgb), 32'(tbl[i].exp_rgb));
      end

      // Test 2: 47 with vCount on the commit line
      vCount = 10'd0;
      offer(10'd47, cyc);
      cmp("t2_busy_cycles", 32'(cyc), 32'(SW + 1));
      px("t2_tens_G", 10'd731, 10'd48, 1'b1);
      px("t2_tens_A", 10'd731, 10'd38, 1'b0);
      px("t2_ones_A", 10'd748, 10'd38, 1'b1);
      px("t2_ones_G", 10'd747, 10'd48, 1'b0);
      px("t2_hund_B", 10'd720, 10'd43, 1'b0);
      cmp("t2_ovf", 32'(ovf), 0);

      // Test 3: saturation
      vCount = 10'd0;
      offer(10'd1000, cyc);
      cmp("t3_busy_cycles", 32'(cyc), 32'(SW + 1));
      cmp("t3_ovf", 32'(ovf), 1);
      px("t3_hund_G", 10'd715, 10'd48, 1'b1);
      px("t3_ones_G", 10'd747, 10'd48, 1'b1);
      px("t3_ones_E", 10'd742, 10'd53, 1'b0);

      // Test 4: commit held off until vCount reaches line 0
      vCount = 10'd100;
      score = 10'd5; score_valid = 1'b1;
      @(posedge clk); #1;
      score_valid = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      cmp("t4_busy_waiting", 32'(busy), 1);
      px("t4_old_hund_B", 10'd720, 10'd43, 1'b1);
      vCount = 10'd100;
      @(posedge clk); #1;
      cmp("t4_ovf_before", 32'(ovf), 1);
      vCount = 10'd0;
      @(posedge clk); #1;
      cmp("t4_busy_after", 32'(busy), 0);
      cmp("t4_ovf_after", 32'(ovf), 0);
      px("t4_new_hund_B", 10'd720, 10'd43, 1'b0);
      px("t4_ones_C", 10'd752, 10'd53, 1'b1);
      px("t4_ones_B", 10'd752, 10'd43, 1'b0);

      // Test 5: score changes while valid is held through the conversion
      vCount = 10'd0;
      score = 10'd123; score_valid = 1'b1;
      @(posedge clk); #1;
      score = 10'd456;
      ready_seen = 1'b0;
      for (int i = 0; i < SW; i++) begin
         if (score_ready) ready_seen = 1'b1;
         @(posedge clk); #1;
      end
      cmp("t5_ready_in_convert", 32'(ready_seen), 0);
      cmp("t5_busy_commit", 32'(busy), 1);
      score_valid = 1'b0;
      @(posedge clk); #1;
      cmp("t5_busy_done", 32'(busy), 0);
      px("t5_ones_E", 10'd742, 10'd53, 1'b0);
      px("t5_tens_E", 10'd726, 10'd53, 1'b1);
      px("t5_tens_C", 10'd736, 10'd53, 1'b0);
      px("t5_hund_B", 10'd720, 10'd43, 1'b1);
      px("t5_hund_A", 10'd715, 10'd38, 1'b0);

      // Test 6: reset in the middle of a conversion
      vCount = 10'd0;
      score = 10'd8; score_valid = 1'b1;
      @(posedge clk); #1;
      score_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      cmp("t6_busy_mid", 32'(busy), 1);
      rst = 1'b1;
      #1;
      cmp("t6_rst_busy", 32'(busy), 0);
      cmp("t6_rst_ready", 32'(score_ready), 1);
      px("t6_ones_A", 10'd748, 10'd38, 1'b1);
      px("t6_ones_G", 10'd747, 10'd48, 1'b0);
      px("t6_hund_B", 10'd720, 10'd43, 1'b0);
      px("t6_tens_E", 10'd726, 10'd53, 1'b0);
      rst = 1'b0;
      vCount = 10'd0;
      @(posedge clk); #1;
      offer(10'd8, cyc);
      cmp("t6_busy_cycles", 32'(cyc), 32'(SW + 1));
      px("t6_new_ones_G", 10'd747, 10'd48, 1'b1);
      px("t6_new_ones_E", 10'd742, 10'd53, 1'b1);
      cmp("t6_ovf", 32'(ovf), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
